// File: rtl/riscv_mem_arbiter.sv
// Purpose: shares one single-ported word memory between the core's fetch path and load/store path.
// Latency: from the IDLE grant cycle, fetch/load done at +2+MEM_LAT, store done at +2, misaligned done at +1.
// Backpressure: requesters hold req/payload until their done pulse; when both contend, the loser waits one transaction.
//
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-low reset
//   if_req/if_addr      - fetch request and byte address; if_done/if_rdata/if_err return the result
//   d_req/d_we/d_addr/d_wdata - data request; d_done/d_rdata/d_err return the result
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - single-ported word memory, read data MEM_LAT cycles after mem_en
//   busy                - high whenever an access is in progress
module riscv_mem_arbiter #(
    parameter int MEM_AW  = 10,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Transaction state
    state_t            state_q, state_d;
    logic              last_dat_q, last_dat_d;   // 1: previous grant went to the data port
    logic              gnt_dat_q, gnt_dat_d;     // 1: current grant belongs to the data port
    logic [2:0]        cnt_q, cnt_d;             // remaining read-latency cycles
    logic              we_q, we_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    // Registered outputs
    logic              if_done_q, if_done_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic              if_err_q, if_err_d;
    logic              d_done_q, d_done_d;
    logic [31:0]       d_rdata_q, d_rdata_d;
    logic              d_err_q, d_err_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    // Arbitration helpers
    logic              pick_dat;
    logic [31:0]       sel_addr;

    // Byte-address bits above the word range and the two offset bits of an
    // aligned access do not reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:MEM_AW+2], d_addr[31:MEM_AW+2]};

    always_comb begin
        state_d     = state_q;
        last_dat_d  = last_dat_q;
        gnt_dat_d   = gnt_dat_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        // Only one requester: it wins. Both: the side not served last time wins.
        if (if_req && d_req) begin
            pick_dat = ~last_dat_q;
        end else begin
            pick_dat = d_req;
        end
        sel_addr = pick_dat ? d_addr : if_addr;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    gnt_dat_d  = pick_dat;
                    last_dat_d = pick_dat;
                    we_d       = pick_dat & d_we;
                    addr_d     = sel_addr[MEM_AW+1:2];
                    wdata_d    = pick_dat ? d_wdata : 32'd0;
                    err_d      = (sel_addr[1:0] != 2'b00);
                    if (sel_addr[1:0] != 2'b00) begin
                        // Misaligned: never touches memory, returns zero data with err.
                        state_d = ST_DONE;
                        if (pick_dat) begin
                            d_rdata_d = 32'd0;
                        end else begin
                            if_rdata_d = 32'd0;
                        end
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'(MEM_LAT);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 3'd1;
                // Count of 1 means mem_rdata is valid this cycle.
                if (cnt_q == 3'd1) begin
                    state_d = ST_DONE;
                    if (gnt_dat_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        mem_en_d    = (state_d == ST_ISSUE);
        mem_we_d    = mem_en_d & we_d;
        mem_addr_d  = mem_en_d ? addr_d : '0;
        mem_wdata_d = mem_en_d ? wdata_d : 32'd0;
        busy_d      = (state_d != ST_IDLE);
        if_done_d   = (state_d == ST_DONE) & ~gnt_dat_d;
        d_done_d    = (state_d == ST_DONE) & gnt_dat_d;
        if_err_d    = if_done_d & err_d;
        d_err_d     = d_done_d & err_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            last_dat_q  <= 1'b1;
            gnt_dat_q   <= 1'b0;
            cnt_q       <= 3'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= 32'd0;
            if_err_q    <= 1'b0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= 32'd0;
            d_err_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_dat_q  <= last_dat_d;
            gnt_dat_q   <= gnt_dat_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            if_done_q   <= if_done_d;
            if_rdata_q  <= if_rdata_d;
            if_err_q    <= if_err_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            d_err_q     <= d_err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
